// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the sprite raster engine.
package sprite_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 12;

    localparam logic [COLOUR_W-1:0] TRANSPARENT = 12'hF0F;
    localparam logic [COLOUR_W-1:0] BG_COLOUR   = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/sprite_raster_counter.sv
// Row-major px/py walker over the sprite; produces the ROM address and last-pixel flag.
module sprite_raster_counter #(
    parameter  int SPR_W  = 16,
    parameter  int SPR_H  = 16,
    localparam int PX_W   = $clog2(SPR_W),
    localparam int PY_W   = $clog2(SPR_H),
    localparam int ADDR_W = PX_W + PY_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [PX_W-1:0]   px,
    output logic [PY_W-1:0]   py,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            // Power-of-two sizes let both counters wrap naturally.
            px <= px + PX_W'(1);
            if (px == PX_W'(SPR_W - 1))
                py <= py + PY_W'(1);
        end
    end

    assign last = (px == PX_W'(SPR_W - 1)) && (py == PY_W'(SPR_H - 1));
    // py*SPR_W + px is a plain concatenation because SPR_W is a power of two.
    assign addr = {py, px};
endmodule

// File: rtl/sprite_blitter.sv
// Sprite raster engine: walks the sprite ROM one pixel per clock and emits clipped,
// transparency-keyed plot strobes for the vga_adapter pixel port.
module sprite_blitter import sprite_pkg::*; #(
    parameter  int                  SPR_W       = 16,
    parameter  int                  SPR_H       = 16,
    parameter  int                  COLOUR_W    = sprite_pkg::COLOUR_W,
    parameter  logic [COLOUR_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT,
    parameter  logic [COLOUR_W-1:0] BG_COLOUR   = sprite_pkg::BG_COLOUR,
    localparam int                  PX_W        = $clog2(SPR_W),
    localparam int                  PY_W        = $clog2(SPR_H),
    localparam int                  ADDR_W      = $clog2(SPR_W * SPR_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic [X_W-1:0]      base_x,
    input  logic [Y_W-1:0]      base_y,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    state_t state, state_nxt;
    logic   accept, cnt_en, last;

    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;

    logic [X_W-1:0] bx_q;
    logic [Y_W-1:0] by_q;
    logic           erase_q;

    logic            a_valid, a_erase;
    logic [PX_W-1:0] a_px;
    logic [PY_W-1:0] a_py;

    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    logic         in_bounds, opaque;

    sprite_raster_counter #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (cnt_en),
        .px     (px),
        .py     (py),
        .last   (last),
        .addr   (rom_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            // DONE behaves like IDLE so back-to-back draws lose no cycle.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx_q    <= '0;
            by_q    <= '0;
            erase_q <= 1'b0;
        end else if (accept) begin
            bx_q    <= base_x;
            by_q    <= base_y;
            erase_q <= erase;
        end
    end

    // Stage A: pixel coordinates travel alongside the synchronous ROM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_px    <= '0;
            a_py    <= '0;
            a_erase <= 1'b0;
        end else begin
            a_valid <= (state == ST_RUN);
            a_px    <= px;
            a_py    <= py;
            a_erase <= erase_q;
        end
    end

    // One extra bit on each sum keeps off-screen pixels from wrapping back on.
    assign sum_x     = {1'b0, bx_q} + (X_W + 1)'(a_px);
    assign sum_y     = {1'b0, by_q} + (Y_W + 1)'(a_py);
    assign in_bounds = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
    assign opaque    = (rom_data != TRANSPARENT);

    // Stage B: registered pixel port plus status flags delayed to line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state == ST_RUN) || (state == ST_FLUSH);
            done <= (state == ST_DONE);
            plot <= a_valid && in_bounds && (a_erase || opaque);
            if (a_valid) begin
                x_out      <= sum_x[X_W-1:0];
                y_out      <= sum_y[Y_W-1:0];
                colour_out <= a_erase ? BG_COLOUR : rom_data;
            end
        end
    end
endmodule
